dest_reg_tracker: RTL and testbench
===================================

Name: dest_reg_tracker

Overview:
- Sits directly downstream of the EX-stage destination-register mux (rt/rd select under RegDst).
- Consumes the selected 5-bit write-register number with its control flags and carries them through internal MEM and WB stage registers.
- From that tracked state it produces forwarding selects for the EX-stage ALU operands and the load-use stall for the hazard path.
- Also keeps a saturating count of load-use stalls for debug.

Parameters:
- REG_ADDR_W, 5, width of a register-file address.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  global pipeline freeze (e.g. memory wait); when 1, all internal registers keep their value.
- ex_flush  in  1  kill the current EX instruction; it enters MEM as a bubble.
- ex_write_reg  in  REG_ADDR_W  destination register from the EX-stage mux.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rs  in  REG_ADDR_W  EX operand A source register.
- ex_rt  in  REG_ADDR_W  EX operand B source register.
- id_rs  in  REG_ADDR_W  ID-stage rs.
- id_rt  in  REG_ADDR_W  ID-stage rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- forward_a  out  2  operand A select: 00 register file, 10 MEM result, 01 WB result.
- forward_b  out  2  operand B select, same encoding.
- load_use_stall  out  1  freeze PC/IF-ID and bubble ID/EX this cycle.
- mem_write_reg  out  REG_ADDR_W  tracked MEM-stage destination.
- mem_reg_write  out  1  tracked MEM-stage write enable.
- wb_write_reg  out  REG_ADDR_W  tracked WB-stage destination.
- wb_reg_write  out  1  tracked WB-stage write enable.
- stall_count  out  STAT_W  number of load-use stall cycles, saturating.

Behaviour:
- Reset: on the rising clk edge with reset=1, all MEM/WB fields (write_reg, reg_write, mem_read) and stall_count clear to 0. reset overrides hold and ex_flush.
- Stage advance: on each edge with reset=0 and hold=0:
  - MEM <= EX fields, or all-zero if ex_flush=1.
  - WB <= MEM fields.
  - The advance is simultaneous, so one instruction moves one stage per cycle.
- hold=1: MEM, WB and stall_count keep their values. The combinational outputs still track their inputs.
- Forwarding (combinational from registered MEM/WB state), forward_a:
  - 10 if mem_reg_write=1, mem_write_reg!=0 and mem_write_reg==ex_rs;
  - otherwise 01 if wb_reg_write=1, wb_write_reg!=0 and wb_write_reg==ex_rs;
  - otherwise 00.
  - MEM always wins over WB.
  - forward_b is identical, using ex_rt.
  - Register 0 never forwards.
- Load-use stall (combinational) is 1 when all of the following hold:
  - ex_mem_read=1, ex_reg_write=1 and ex_write_reg!=0;
  - ex_flush=0;
  - (id_uses_rs=1 and id_rs==ex_write_reg) or (id_uses_rt=1 and id_rt==ex_write_reg).
- Stall rules:
  - A load never forwards from MEM to a dependent instruction one stage behind; the stall inserts exactly one bubble, after which the WB path serves it.
  - The upstream ID/EX register inserts the bubble. This block only sees it as ex_reg_write=0 on the following cycle.
- stall_count: increments by 1 on each edge where load_use_stall=1, hold=0 and reset=0. It saturates at 2^STAT_W-1 and does not wrap.
- Simultaneous events:
  - ex_flush and a load-use match in the same cycle: no stall, because the load is killed.
  - hold and a stall in the same cycle: the stall is asserted but not counted.
- Reset mid-operation: the tracked writes are discarded. Forward selects go to 00 on the cycle after reset.
- Outputs mem_* and wb_* are direct register outputs, with zero latency from the register.

Decomposition:
- Shared package (MIPS pipeline package):
  - REG_ADDR_W;
  - forward-select constants FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - a stage-record bundle {write_reg, reg_write, mem_read}.
- One natural sub-module: fwd_select. It is a purely combinational per-operand comparator, instantiated twice (operand A and operand B).

Test Plan:
- Reset then idle: assert reset 1 cycle with random inputs -> every output reads 0; stall_count=0.
- EX->MEM forward: EX add with write_reg=8 and reg_write=1; next cycle ex_rs=8 -> forward_a=10 for that cycle; one cycle later with ex_rs=8 still applied -> forward_a=01.
- Priority and $0: MEM dest=5 and WB dest=5, ex_rt=5 -> forward_b=10. Repeat with dest=0 -> forward_b=00.
- Load-use: EX load with write_reg=9, mem_read=1; id_rt=9, id_uses_rt=1 -> load_use_stall=1 and stall_count becomes 1 after the edge. The same case with id_uses_rt=0 -> load_use_stall=0.
- Flush and hold: the load from the previous case plus ex_flush=1 -> stall=0, and after the edge mem_reg_write=0. With hold=1 for 3 cycles -> MEM/WB values and stall_count unchanged.
- Saturation: with STAT_W=4, apply 20 consecutive stall cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/dest_reg_tracker_pkg.sv
// Shared MIPS pipeline definitions: register address width, forwarding selects
// and the per-stage destination record carried through MEM and WB.
package dest_reg_tracker_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  reg_write;
    logic                  mem_read;
  } stage_rec_t;

endpackage

// File: rtl/dest_reg_tracker_fwd_select.sv
// Per-operand forwarding comparator: picks MEM over WB over the register file,
// and never forwards register 0.
module dest_reg_tracker_fwd_select
  import dest_reg_tracker_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic                  wb_reg_write,
  output logic [1:0]            sel_c
);

  always_comb begin
    sel_c = FWD_REGFILE;
    if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == src)) begin
      sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == src)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks the EX destination register through MEM and WB, derives operand
// forwarding selects and the load-use stall, and counts stall cycles.
module dest_reg_tracker
  import dest_reg_tracker_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  ex_flush,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  load_use_stall,
  output logic [REG_ADDR_W-1:0] mem_write_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic                  wb_reg_write,
  output logic [STAT_W-1:0]     stall_count
);

  stage_rec_t          ex_rec;
  stage_rec_t          mem_q;
  stage_rec_t          wb_q;
  logic [STAT_W-1:0]   stall_cnt_q;
  logic                unused_wb_mem_read;

  assign ex_rec = '{write_reg: ex_write_reg, reg_write: ex_reg_write, mem_read: ex_mem_read};

  // A killed load cannot stall anything; register 0 is never a real dependency.
  always_comb begin
    load_use_stall = 1'b0;
    if (ex_mem_read && ex_reg_write && (ex_write_reg != '0) && !ex_flush) begin
      load_use_stall = (id_uses_rs && (id_rs == ex_write_reg)) ||
                       (id_uses_rt && (id_rt == ex_write_reg));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (!hold) begin
      mem_q <= ex_flush ? stage_rec_t'('0) : ex_rec;
      wb_q  <= mem_q;
      if (load_use_stall && (stall_cnt_q != {STAT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
    end
  end

  dest_reg_tracker_fwd_select u_fwd_a (
    .src           (ex_rs),
    .mem_write_reg (mem_q.write_reg),
    .mem_reg_write (mem_q.reg_write),
    .wb_write_reg  (wb_q.write_reg),
    .wb_reg_write  (wb_q.reg_write),
    .sel_c         (forward_a)
  );

  dest_reg_tracker_fwd_select u_fwd_b (
    .src           (ex_rt),
    .mem_write_reg (mem_q.write_reg),
    .mem_reg_write (mem_q.reg_write),
    .wb_write_reg  (wb_q.write_reg),
    .wb_reg_write  (wb_q.reg_write),
    .sel_c         (forward_b)
  );

  assign mem_write_reg = mem_q.write_reg;
  assign mem_reg_write = mem_q.reg_write;
  assign wb_write_reg  = wb_q.write_reg;
  assign wb_reg_write  = wb_q.reg_write;
  assign stall_count   = stall_cnt_q;

  // WB-stage load flag is tracked for completeness but has no consumer here.
  assign unused_wb_mem_read = wb_q.mem_read;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker with a 4-bit stall counter.
module tb_dest_reg_tracker;

  localparam int unsigned AW = 5;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          reset, hold, ex_flush;
  logic [AW-1:0] ex_write_reg, ex_rs, ex_rt, id_rs, id_rt;
  logic          ex_reg_write, ex_mem_read, id_uses_rs, id_uses_rt;
  logic [1:0]    forward_a, forward_b;
  logic          load_use_stall;
  logic [AW-1:0] mem_write_reg, wb_write_reg;
  logic          mem_reg_write, wb_reg_write;
  logic [SW-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dest_reg_tracker #(.STAT_W(SW)) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .ex_flush       (ex_flush),
    .ex_write_reg   (ex_write_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .load_use_stall (load_use_stall),
    .mem_write_reg  (mem_write_reg),
    .mem_reg_write  (mem_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_reg_write   (wb_reg_write),
    .stall_count    (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hold = 0; ex_flush = 0;
    ex_write_reg = '0; ex_reg_write = 0; ex_mem_read = 0;
    ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0;
  endtask

  initial begin
    // Reset with random inputs, then idle
    reset = 1; hold = 1'($urandom); ex_flush = 1'($urandom);
    ex_write_reg = AW'($urandom); ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
    ex_rs = AW'($urandom); ex_rt = AW'($urandom); id_rs = AW'($urandom); id_rt = AW'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
    #2;
    tick();
    reset = 0;
    clear_inputs();
    #1;
    check("rst_mem_reg", 32'(mem_write_reg), 32'd0);
    check("rst_mem_we", 32'(mem_reg_write), 32'd0);
    check("rst_wb_reg", 32'(wb_write_reg), 32'd0);
    check("rst_wb_we", 32'(wb_reg_write), 32'd0);
    check("rst_fwd_a", 32'(forward_a), 32'd0);
    check("rst_fwd_b", 32'(forward_b), 32'd0);
    check("rst_stall", 32'(load_use_stall), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);

    // EX add to $8, then dependent reads from MEM and WB
    ex_write_reg = 5'd8; ex_reg_write = 1;
    tick();
    ex_write_reg = '0; ex_reg_write = 0; ex_rs = 5'd8;
    #1;
    check("mem_fwd_a", 32'(forward_a), 32'h2);
    check("mem_reg8", 32'(mem_write_reg), 32'd8);
    check("mem_we8", 32'(mem_reg_write), 32'd1);
    tick();
    check("wb_fwd_a", 32'(forward_a), 32'h1);
    check("wb_reg8", 32'(wb_write_reg), 32'd8);

    // MEM and WB both target $5: MEM wins
    ex_rs = '0; ex_write_reg = 5'd5; ex_reg_write = 1;
    tick();
    tick();
    ex_rt = 5'd5;
    #1;
    check("prio_fwd_b", 32'(forward_b), 32'h2);
    // Same with $0: never forwards
    ex_write_reg = '0;
    tick();
    tick();
    ex_rt = '0;
    #1;
    check("zero_mem_we", 32'(mem_reg_write), 32'd1);
    check("zero_fwd_b", 32'(forward_b), 32'h0);

    // Load $9 with dependent rt in ID
    ex_write_reg = 5'd9; ex_reg_write = 1; ex_mem_read = 1;
    id_rt = 5'd9; id_uses_rt = 1;
    #1;
    check("lu_stall", 32'(load_use_stall), 32'd1);
    tick();
    check("lu_count", 32'(stall_count), 32'd1);
    id_uses_rt = 0;
    #1;
    check("lu_nouse", 32'(load_use_stall), 32'd0);

    // Flushed load: no stall, bubble enters MEM
    id_uses_rt = 1; ex_flush = 1;
    #1;
    check("flush_stall", 32'(load_use_stall), 32'd0);
    tick();
    check("flush_mem_we", 32'(mem_reg_write), 32'd0);
    check("flush_count", 32'(stall_count), 32'd1);
    check("flush_wb_reg", 32'(wb_write_reg), 32'd9);

    // Hold for 3 cycles with a stall pending: state frozen, stall not counted
    ex_flush = 0; hold = 1; ex_rs = 5'd9;
    #1;
    check("hold_stall", 32'(load_use_stall), 32'd1);
    check("hold_fwd_a", 32'(forward_a), 32'h1);
    tick(); tick(); tick();
    check("hold_mem_reg", 32'(mem_write_reg), 32'd0);
    check("hold_mem_we", 32'(mem_reg_write), 32'd0);
    check("hold_wb_reg", 32'(wb_write_reg), 32'd9);
    check("hold_wb_we", 32'(wb_reg_write), 32'd1);
    check("hold_count", 32'(stall_count), 32'd1);

    // 20 consecutive stall cycles: 1 + 20 saturates at 15
    hold = 0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_count", 32'(stall_count), 32'd15);

    // Reset mid-operation discards tracked writes
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    ex_rs = 5'd9; ex_rt = 5'd9;
    #1;
    check("mrst_fwd_a", 32'(forward_a), 32'h0);
    check("mrst_fwd_b", 32'(forward_b), 32'h0);
    check("mrst_mem_we", 32'(mem_reg_write), 32'd0);
    check("mrst_wb_we", 32'(wb_reg_write), 32'd0);
    check("mrst_count", 32'(stall_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
